router_cfg_chain_loader: RTL and testbench
==========================================

# router_cfg_chain_loader

Sequencer that loads the router's configuration flip-flop chain (CHAIN_LEN DFFR cells between `ccff_head` and `ccff_tail`) from a word-wide bitstream source. It serialises words from a valid/ready stream onto `ccff_head` and issues one shift-enable per bit. An optional verify pass re-shifts the same bitstream and compares the bits emerging at `ccff_tail`. It sits between the configuration-protocol front end and each router's configuration memory, on the programming clock domain.

## Interface
- `CHAIN_LEN`, 112: number of flops in the target chain, ≥1.
- `WORD_W`, 32: bitstream word width, ≥1.
- `CNT_W`, $clog2(CHAIN_LEN+1): width of bit counters.
- `prog_clk` in 1: the single clock, rising edge.
- `pReset` in 1: reset, asynchronous, active-high; clears all state.
- `start` in 1: one-cycle request to begin a pass; ignored unless IDLE.
- `verify` in 1: sampled with `start`; 1 = verify pass, 0 = load pass.
- `abort` in 1: terminate current pass.
- `cfg_word` in WORD_W: bitstream word, bit 0 shifted first.
- `cfg_valid` in 1: `cfg_word` valid.
- `cfg_ready` out 1: loader accepts a word this cycle.
- `ccff_head` out 1: serial bit to chain input.
- `ccff_shift_en` out 1: chain clock enable; chain captures `ccff_head` at the edge ending a cycle with this high.
- `ccff_tail` in 1: chain output (last flop Q).
- `busy` out 1: pass in progress.
- `done` out 1: one-cycle pulse at pass completion.
- `mismatch` out 1: sticky verify error flag.
- `err_bit` out CNT_W: bit index of first verify mismatch.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE: `busy`=0, `cfg_ready`=0. On `start`=1: latch `verify`; clear `mismatch`, `err_bit`, `bit_cnt`; go to LOAD.
- LOAD: `cfg_ready`=1. On `cfg_valid`&`cfg_ready`: capture word into shift register; set `word_bits` = min(WORD_W, CHAIN_LEN−`bit_cnt`); go to SHIFT.
- SHIFT: `ccff_shift_en`=1; `ccff_head` = shift_reg[0]. Each cycle, shift the register right by 1, increment `bit_cnt`, and decrement `word_bits`. When the last bit of the word is shifted, go to DONE if `bit_cnt` reaches CHAIN_LEN, else go to LOAD.
- Unused high bits of the final partial word are discarded and never shifted.
- DONE: `done`=1 for one cycle, `busy`=1; go to IDLE.
- Verify pass: source re-sends the identical bitstream. The loader shifts as for a load pass. In every SHIFT cycle it compares `ccff_tail` with `ccff_head`; the chain is FIFO, so the tail before shift k holds bit k of the previous pass. On the first inequality it sets `mismatch` and `err_bit` = current `bit_cnt`. Later mismatches do not change `err_bit`. The chain is left reloaded with the same data.
- `abort` in any non-IDLE state: go to IDLE next cycle with no `done`. `mismatch` and `err_bit` hold. Chain contents are undefined.
- `abort` has priority over the handshake and over shifting in the same cycle: no word is accepted and no shift occurs.
- `start` while busy: ignored.

## Timing
- Reset values: state IDLE, `cfg_ready`=0, `ccff_head`=0, `ccff_shift_en`=0, `busy`=0, `done`=0, `mismatch`=0, `err_bit`=0.
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.
- `start` sampled at edge E0 → LOAD from cycle 1 (`busy`=1, `cfg_ready`=1).
- After a word handshake at edge E: the first shift cycle is E+1. There are exactly `word_bits` consecutive `ccff_shift_en` cycles, and `cfg_ready`=0 throughout.
- Per word, with `cfg_valid` held high: 1 handshake cycle + `word_bits` shift cycles.
- Default parameters, continuous valid: 4 words (32,32,32,16 bits) take 116 cycles; `done` is high in cycle 117 after E0.
- `cfg_valid` low in LOAD: the loader stalls indefinitely with no shift.
- `pReset` mid-pass: immediate return to reset values. A partially loaded chain is not restored.
- The `mismatch` comparison uses `ccff_tail` sampled in the same cycle as the corresponding `ccff_shift_en`.

## Test plan
- Load pass, CHAIN_LEN=112, words 0xDEADBEEF, 0x01234567, 0x89ABCDEF, 0xFFFF5A5A (last word uses low 16 bits only), valid always high → exactly 112 shift cycles, `done` in cycle 117, chain model mem_out[111..0] equals stream bit order, tail = bit 0.
- Verify pass after that load with the identical stream → `mismatch`=0, `done` at cycle 117, chain unchanged.
- Verify pass with bit 37 flipped (word 1, bit 5) → `mismatch`=1, `err_bit`=37; a second flip at bit 90 leaves `err_bit`=37.
- `cfg_valid` toggled 1-0-0-1 in LOAD, plus `start` pulsed mid-SHIFT → shifts occur only after handshakes, total 112; the extra `start` has no effect.
- `abort` asserted in a cycle with `cfg_valid`=1 in LOAD, and again at shift 50 of a later pass → no word accepted, no `done`, IDLE next cycle, `cfg_ready`=0.
- `pReset` pulsed asynchronously mid-SHIFT at bit 20 → all outputs are at reset values before the next edge, and a subsequent full load completes normally.

Source files
------------

// File: rtl/router_cfg_chain_loader.sv
// Loads the router configuration flip-flop chain from a word-wide bitstream,
// LSB first, with an optional verify pass that compares the bits leaving the chain tail.
module router_cfg_chain_loader #(
    parameter int CHAIN_LEN = 112,
    parameter int WORD_W    = 32,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_word,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [CNT_W-1:0]  err_bit
);

    localparam int WB_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    logic [WORD_W-1:0] shift_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [WB_W-1:0]   word_bits_r;
    logic              verify_r;
    logic              mismatch_r;
    logic [CNT_W-1:0]  err_bit_r;
    logic [31:0]       remain_s;
    logic [WB_W-1:0]   word_bits_s;

    // Bits still owed to the chain, capped at one word; the final word may be partial.
    always_comb begin
        remain_s = 32'(CHAIN_LEN) - 32'(bit_cnt_r);
        if (remain_s > 32'(WORD_W)) begin
            word_bits_s = WB_W'(WORD_W);
        end else begin
            word_bits_s = WB_W'(remain_s);
        end
    end

    // Outputs decode the state register and datapath flops only.
    assign cfg_ready     = (state_r == LOAD);
    assign ccff_shift_en = (state_r == SHIFT);
    assign ccff_head     = (state_r == SHIFT) & shift_r[0];
    assign busy          = (state_r != IDLE);
    assign done          = (state_r == DONE);
    assign mismatch      = mismatch_r;
    assign err_bit       = err_bit_r;

    // Pass sequencer: word handshake, serialisation and verify comparison.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_r     <= IDLE;
            shift_r     <= '0;
            bit_cnt_r   <= '0;
            word_bits_r <= '0;
            verify_r    <= 1'b0;
            mismatch_r  <= 1'b0;
            err_bit_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        verify_r   <= verify;
                        mismatch_r <= 1'b0;
                        err_bit_r  <= '0;
                        bit_cnt_r  <= '0;
                        state_r    <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state_r <= IDLE;
                    end else if (cfg_valid) begin
                        shift_r     <= cfg_word;
                        word_bits_r <= word_bits_s;
                        state_r     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state_r <= IDLE;
                    end else begin
                        shift_r     <= shift_r >> 1;
                        bit_cnt_r   <= bit_cnt_r + CNT_W'(1);
                        word_bits_r <= word_bits_r - WB_W'(1);
                        // Chain is a FIFO: the tail now holds this same bit from the previous pass.
                        if (verify_r && !mismatch_r && (ccff_tail != shift_r[0])) begin
                            mismatch_r <= 1'b1;
                            err_bit_r  <= bit_cnt_r;
                        end
                        if (word_bits_r == WB_W'(1)) begin
                            state_r <= (bit_cnt_r == CNT_W'(CHAIN_LEN - 1)) ? DONE : LOAD;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_cfg_chain_loader.sv
// Directed bench for router_cfg_chain_loader with a behavioural 112-flop chain model.
module tb_router_cfg_chain_loader;

    logic        prog_clk = 1'b0;
    logic        pReset;
    logic        start;
    logic        verify;
    logic        abort;
    logic [31:0] cfg_word;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        ccff_head;
    logic        ccff_shift_en;
    logic        ccff_tail;
    logic        busy;
    logic        done;
    logic        mismatch;
    logic [6:0]  err_bit;

    logic [111:0] chain = '0;
    logic [127:0] s_words;
    int total = 0;
    int bad   = 0;

    router_cfg_chain_loader #(.CHAIN_LEN(112), .WORD_W(32)) dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .verify(verify),
        .abort(abort), .cfg_word(cfg_word), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
        .busy(busy), .done(done), .mismatch(mismatch), .err_bit(err_bit)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: mem_out[0] is the head flop, mem_out[111] drives the tail.
    always @(posedge prog_clk) begin
        if (ccff_shift_en) chain <= {chain[110:0], ccff_head};
    end
    assign ccff_tail = chain[111];

    function automatic logic [111:0] exp_of(input logic [127:0] w);
        logic [111:0] e;
        for (int k = 0; k < 112; k++) e[111-k] = w[k];
        return e;
    endfunction

    // Runs one pass from IDLE; returns measurements, the caller judges them.
    task automatic drive_pass(input logic vfy, input logic [127:0] w, input bit stall,
                              input bit mid_start, input int abort_at, input int reset_at,
                              output int shifts, output int done_cyc, output int stall_viol,
                              output bit timeout);
        int  widx;
        bit  hs;
        bit  was_stall;
        shifts = 0; done_cyc = 0; stall_viol = 0; timeout = 1'b1; widx = 0; was_stall = 1'b0;
        start = 1'b1; verify = vfy;
        @(posedge prog_clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            cfg_word  = (widx < 4) ? w[32*widx +: 32] : 32'h0;
            cfg_valid = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (done) begin
                done_cyc = cyc;
                timeout  = 1'b0;
                break;
            end
            if (was_stall && ccff_shift_en) stall_viol++;
            if (ccff_shift_en) begin
                if (shifts == abort_at) begin
                    abort = 1'b1;
                end else if (shifts == reset_at) begin
                    #2 pReset = 1'b1;
                    #1 cfg_valid = 1'b0;
                    timeout = 1'b0;
                    return;
                end else begin
                    shifts++;
                end
            end
            start = (mid_start && shifts == 10) ? 1'b1 : 1'b0;
            was_stall = cfg_ready && !cfg_valid;
            hs = cfg_ready && cfg_valid;
            @(posedge prog_clk); #1;
            if (hs) widx++;
            if (abort) begin
                abort = 1'b0; cfg_valid = 1'b0; timeout = 1'b0;
                return;
            end
        end
        cfg_valid = 1'b0; start = 1'b0;
        @(posedge prog_clk); #1;
    endtask

    task automatic test_reset();
        pReset = 1'b1; start = 1'b0; verify = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_word = 32'h0;
        repeat (3) @(posedge prog_clk);
        #1;
        total++;
        if ({cfg_ready, ccff_head, ccff_shift_en, busy, done, mismatch} !== 6'b0) begin
            bad++; $display("FAIL reset_outputs got=%b want=000000",
                            {cfg_ready, ccff_head, ccff_shift_en, busy, done, mismatch});
        end
        total++;
        if (err_bit !== 7'd0) begin bad++; $display("FAIL reset_err_bit got=%0d want=0", err_bit); end
        pReset = 1'b0;
        @(posedge prog_clk); #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_load();
        int sh, dc, sv; bit to;
        drive_pass(1'b0, s_words, 1'b0, 1'b0, -1, -1, sh, dc, sv, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL load_timeout got=1 want=0"); end
        total++; if (sh != 112) begin bad++; $display("FAIL load_shifts got=%0d want=112", sh); end
        total++; if (dc != 117) begin bad++; $display("FAIL load_done_cycle got=%0d want=117", dc); end
        total++;
        if (chain !== exp_of(s_words)) begin
            bad++; $display("FAIL load_chain got=%h want=%h", chain, exp_of(s_words));
        end
        total++; if (ccff_tail !== 1'b1) begin bad++; $display("FAIL load_tail got=%b want=1", ccff_tail); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL load_idle_after got=%b want=0", busy); end
    endtask

    task automatic test_verify_ok();
        int sh, dc, sv; bit to;
        drive_pass(1'b1, s_words, 1'b0, 1'b0, -1, -1, sh, dc, sv, to);
        total++; if (dc != 117) begin bad++; $display("FAIL vok_done_cycle got=%0d want=117", dc); end
        total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL vok_mismatch got=%b want=0", mismatch); end
        total++;
        if (chain !== exp_of(s_words)) begin
            bad++; $display("FAIL vok_chain got=%h want=%h", chain, exp_of(s_words));
        end
    endtask

    task automatic test_verify_flip();
        int sh, dc, sv; bit to;
        logic [127:0] w;
        w = s_words; w[37] = ~w[37];
        drive_pass(1'b1, w, 1'b0, 1'b0, -1, -1, sh, dc, sv, to);
        total++; if (mismatch !== 1'b1) begin bad++; $display("FAIL vflip_mismatch got=%b want=1", mismatch); end
        total++; if (err_bit !== 7'd37) begin bad++; $display("FAIL vflip_err_bit got=%0d want=37", err_bit); end
        total++;
        if (chain !== exp_of(w)) begin bad++; $display("FAIL vflip_chain got=%h want=%h", chain, exp_of(w)); end
        drive_pass(1'b0, s_words, 1'b0, 1'b0, -1, -1, sh, dc, sv, to);
        total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL reload_clears got=%b want=0", mismatch); end
        w = s_words; w[37] = ~w[37]; w[90] = ~w[90];
        drive_pass(1'b1, w, 1'b0, 1'b0, -1, -1, sh, dc, sv, to);
        total++; if (mismatch !== 1'b1) begin bad++; $display("FAIL vflip2_mismatch got=%b want=1", mismatch); end
        total++; if (err_bit !== 7'd37) begin bad++; $display("FAIL vflip2_err_bit got=%0d want=37", err_bit); end
        drive_pass(1'b0, s_words, 1'b0, 1'b0, -1, -1, sh, dc, sv, to);
    endtask

    task automatic test_stall();
        int sh, dc, sv; bit to;
        drive_pass(1'b0, s_words, 1'b1, 1'b1, -1, -1, sh, dc, sv, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL stall_timeout got=1 want=0"); end
        total++; if (sh != 112) begin bad++; $display("FAIL stall_shifts got=%0d want=112", sh); end
        total++; if (sv != 0) begin bad++; $display("FAIL stall_shift_without_hs got=%0d want=0", sv); end
        total++;
        if (chain !== exp_of(s_words)) begin
            bad++; $display("FAIL stall_chain got=%h want=%h", chain, exp_of(s_words));
        end
        repeat (3) begin
            total++;
            if ({busy, done} !== 2'b00) begin bad++; $display("FAIL stall_no_restart got=%b want=00", {busy, done}); end
            @(posedge prog_clk); #1;
        end
    endtask

    task automatic test_abort();
        int sh, dc, sv; bit to;
        logic [127:0] w;
        start = 1'b1; verify = 1'b0;
        @(posedge prog_clk); #1;
        start = 1'b0;
        total++;
        if ({busy, cfg_ready} !== 2'b11) begin bad++; $display("FAIL abort_load_state got=%b want=11", {busy, cfg_ready}); end
        cfg_word = s_words[31:0]; cfg_valid = 1'b1; abort = 1'b1;
        @(posedge prog_clk); #1;
        abort = 1'b0; cfg_valid = 1'b0;
        total++;
        if ({busy, cfg_ready, ccff_shift_en, done} !== 4'b0) begin
            bad++; $display("FAIL abort_load_idle got=%b want=0000", {busy, cfg_ready, ccff_shift_en, done});
        end
        @(posedge prog_clk); #1;
        total++;
        if ({ccff_shift_en, done} !== 2'b00) begin bad++; $display("FAIL abort_load_no_word got=%b want=00", {ccff_shift_en, done}); end
        w = s_words; w[37] = ~w[37];
        drive_pass(1'b1, w, 1'b0, 1'b0, 50, -1, sh, dc, sv, to);
        total++; if (sh != 50) begin bad++; $display("FAIL abort_shift_count got=%0d want=50", sh); end
        total++;
        if ({busy, done, ccff_shift_en, cfg_ready} !== 4'b0) begin
            bad++; $display("FAIL abort_shift_idle got=%b want=0000", {busy, done, ccff_shift_en, cfg_ready});
        end
        total++; if (mismatch !== 1'b1) begin bad++; $display("FAIL abort_mismatch_hold got=%b want=1", mismatch); end
        total++; if (err_bit !== 7'd37) begin bad++; $display("FAIL abort_err_hold got=%0d want=37", err_bit); end
        @(posedge prog_clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b want=0", done); end
        drive_pass(1'b0, s_words, 1'b0, 1'b0, -1, -1, sh, dc, sv, to);
        total++; if (dc != 117) begin bad++; $display("FAIL abort_reload_done got=%0d want=117", dc); end
    endtask

    task automatic test_reset_mid();
        int sh, dc, sv; bit to;
        logic [127:0] w;
        w = s_words; w[5] = ~w[5];
        drive_pass(1'b1, w, 1'b0, 1'b0, -1, 20, sh, dc, sv, to);
        total++;
        if ({cfg_ready, ccff_head, ccff_shift_en, busy, done, mismatch} !== 6'b0) begin
            bad++; $display("FAIL rst_mid_outputs got=%b want=000000",
                            {cfg_ready, ccff_head, ccff_shift_en, busy, done, mismatch});
        end
        total++; if (err_bit !== 7'd0) begin bad++; $display("FAIL rst_mid_err_bit got=%0d want=0", err_bit); end
        @(posedge prog_clk); #1;
        pReset = 1'b0; start = 1'b0;
        @(posedge prog_clk); #1;
        drive_pass(1'b0, s_words, 1'b0, 1'b0, -1, -1, sh, dc, sv, to);
        total++; if (sh != 112) begin bad++; $display("FAIL rst_reload_shifts got=%0d want=112", sh); end
        total++; if (dc != 117) begin bad++; $display("FAIL rst_reload_done got=%0d want=117", dc); end
        total++;
        if (chain !== exp_of(s_words)) begin
            bad++; $display("FAIL rst_reload_chain got=%h want=%h", chain, exp_of(s_words));
        end
    endtask

    initial begin
        s_words = {32'hFFFF5A5A, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF};
        test_reset();
        test_load();
        test_verify_ok();
        test_verify_flip();
        test_stall();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
